filt_sample_feeder: RTL

- Upstream stage of the `filters` FIR block.
- Accepts the XADC sample stream, decimates it, and buffers samples in a small FIFO.
- Hands samples one at a time to the filter using the `filt_start` / `filt_done` handshake.
- Absorbs XADC samples that arrive while the filter is still computing its M-tap result, and reports any overflow.

---
 rtl/filt_sample_feeder_if.sv | 27 ++
 rtl/filt_sample_feeder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filt_sample_feeder_if.sv
// Sample-stream and filter-handshake bundle for filt_sample_feeder.
// master = feeder side, slave = XADC source / filter side.
interface filt_sample_feeder_if #(
    parameter int XADC_DATA_SIZE = 16
);
    logic                      s_valid;
    logic [XADC_DATA_SIZE-1:0] s_data;
    logic                      filt_start;
    logic [XADC_DATA_SIZE-1:0] filt_data;
    logic                      filt_done;

    modport master (
        input  s_valid,
        input  s_data,
        input  filt_done,
        output filt_start,
        output filt_data
    );

    modport slave (
        output s_valid,
        output s_data,
        output filt_done,
        input  filt_start,
        input  filt_data
    );
endinterface

// File: rtl/filt_sample_feeder.sv
// Decimates the XADC stream, buffers it in a small FIFO and feeds the FIR one sample
// per filt_start/filt_done handshake. Optional WAIT watchdog: define FEEDER_TIMEOUT_EN.
module filt_sample_feeder #(
    parameter int XADC_DATA_SIZE = 16,
    parameter int FIFO_AW        = 4,
    parameter int DIV_WIDTH      = 16,
    parameter int START_CYCLES   = 2,
    parameter int DROP_CNT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [DIV_WIDTH-1:0]      div,
    input  logic                      clr_status,
    filt_sample_feeder_if.master      bus,
    output logic [FIFO_AW:0]          fifo_level,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic                      busy,
    output logic                      timeout
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int SCW   = $clog2(START_CYCLES + 1);

    localparam logic [FIFO_AW:0]          FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]          LVL_ONE    = (FIFO_AW + 1)'(1'b1);
    localparam logic [FIFO_AW-1:0]        PTR_ONE    = FIFO_AW'(1'b1);
    localparam logic [DIV_WIDTH-1:0]      DIV_ONE    = DIV_WIDTH'(1'b1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE   = DROP_CNT_WIDTH'(1'b1);
    localparam logic [SCW-1:0]            SC_ONE     = SCW'(1'b1);
    localparam logic [SCW-1:0]            START_LAST = SCW'(START_CYCLES);

    if (START_CYCLES < 1 || TIMEOUT_CYCLES < 2 || FIFO_AW < 1) begin : g_bad_params
        $error("filt_sample_feeder: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      state_s;
    logic [DIV_WIDTH-1:0]        dcnt_r;
    logic [DIV_WIDTH-1:0]        div_r;
    logic [DIV_WIDTH-1:0]        div_eff_s;
    logic [FIFO_AW-1:0]          wr_ptr_r;
    logic [FIFO_AW-1:0]          rd_ptr_r;
    logic [FIFO_AW:0]            count_r;
    logic [XADC_DATA_SIZE-1:0]   mem_r [DEPTH];
    logic [SCW-1:0]              scnt_r;
    logic                        done_q_r;
    logic                        filt_start_r;
    logic [XADC_DATA_SIZE-1:0]   filt_data_r;
    logic                        overflow_r;
    logic [DROP_CNT_WIDTH-1:0]   drop_cnt_r;
    logic                        busy_r;
    logic                        sample_s;
    logic                        wrap_s;
    logic                        push_req_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        drop_s;
    logic                        empty_s;
    logic                        full_s;
    logic                        rise_s;
    logic                        wd_expire_s;

    // Input qualification, decimation tap and FIFO accept/drop decisions
    always_comb begin
        sample_s   = en & bus.s_valid;
        // A new decimation period latches div at its first sample, so a div change
        // only affects the period after the current wrap.
        if (dcnt_r == {DIV_WIDTH{1'b0}}) begin
            div_eff_s = div;
        end else begin
            div_eff_s = div_r;
        end
        wrap_s     = (dcnt_r == div_eff_s);
        push_req_s = sample_s & (dcnt_r == {DIV_WIDTH{1'b0}});
        empty_s    = (count_r == {(FIFO_AW + 1){1'b0}});
        full_s     = (count_r == FULL_LEVEL);
        push_s     = push_req_s & (~full_s | pop_s);
        drop_s     = push_req_s & full_s & ~pop_s;
        rise_s     = bus.filt_done & ~done_q_r;
    end

    // Dispatch FSM next-state and pop decision
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (en && !empty_s) begin
                    state_s = START;
                    pop_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (scnt_r == START_LAST) begin
                    state_s = WAIT;
                end else begin
                    state_s = START;
                end
            end
            WAIT: begin
                if (rise_s || wd_expire_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, start-pulse timing, presented sample and done history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            scnt_r       <= {SCW{1'b0}};
            filt_start_r <= 1'b0;
            filt_data_r  <= {XADC_DATA_SIZE{1'b0}};
            busy_r       <= 1'b0;
            done_q_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            busy_r   <= (state_s != IDLE);
            done_q_r <= bus.filt_done;
            // filt_start trails the pop by one cycle so filt_data is settled first
            if (state_r == START) begin
                scnt_r       <= scnt_r + SC_ONE;
                filt_start_r <= (scnt_r != START_LAST);
            end else begin
                scnt_r       <= {SCW{1'b0}};
                filt_start_r <= 1'b0;
            end
            if (pop_s) begin
                filt_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Decimation counter and FIFO pointers/occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_r   <= {DIV_WIDTH{1'b0}};
            div_r    <= {DIV_WIDTH{1'b0}};
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= {(FIFO_AW + 1){1'b0}};
        end else begin
            if (sample_s) begin
                if (wrap_s) begin
                    dcnt_r <= {DIV_WIDTH{1'b0}};
                end else begin
                    dcnt_r <= dcnt_r + DIV_ONE;
                end
                if (dcnt_r == {DIV_WIDTH{1'b0}}) begin
                    div_r <= div;
                end
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + LVL_ONE;
                2'b01:   count_r <= count_r - LVL_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; when full with a simultaneous pop the head is read before overwrite
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.s_data;
        end
    end

    // Sticky overflow and saturating drop counter; a drop beats clr_status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {DROP_CNT_WIDTH{1'b0}};
        end else begin
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (clr_status) begin
                    drop_cnt_r <= DROP_ONE;
                end else if (drop_cnt_r != {DROP_CNT_WIDTH{1'b1}}) begin
                    drop_cnt_r <= drop_cnt_r + DROP_ONE;
                end
            end else if (clr_status) begin
                overflow_r <= 1'b0;
                drop_cnt_r <= {DROP_CNT_WIDTH{1'b0}};
            end
        end
    end

`ifdef FEEDER_TIMEOUT_EN
    localparam int             TW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  WD_ONE  = TW'(1'b1);

    logic [TW-1:0] wcnt_r;
    logic          timeout_r;

    assign wd_expire_s = (state_r == WAIT) && (wcnt_r == TO_LAST);

    // WAIT watchdog: counts cycles spent in WAIT and latches a sticky timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r    <= {TW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            if (state_r == WAIT) begin
                wcnt_r <= wcnt_r + WD_ONE;
            end else begin
                wcnt_r <= {TW{1'b0}};
            end
            if (wd_expire_s && !rise_s) begin
                timeout_r <= 1'b1;
            end else if (clr_status) begin
                timeout_r <= 1'b0;
            end
        end
    end

    assign timeout = timeout_r;
`else
    assign wd_expire_s = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign bus.filt_start = filt_start_r;
    assign bus.filt_data  = filt_data_r;
    assign fifo_level     = count_r;
    assign overflow       = overflow_r;
    assign drop_count     = drop_cnt_r;
    assign busy           = busy_r;

endmodule
